mem_arb_ctrl: RTL
=================

// Module: mem_arb_ctrl
// PURPOSE
//  Multi-requester front end for a single-port word memory with N_PORTS channels.
//  Each channel has a request/grant handshake; one access (read or write) is granted per cycle.
//  Writes carry byte strobes. Read data returns with READ_LAT cycles of latency, tagged per channel.
//  Sits between the cache fill/evict/fetch paths and the backing store.
// PARAMETERS
//  N_PORTS     4   number of requester channels (>=2)
//  MEM_DEPTH   32  words in memory; AW = $clog2(MEM_DEPTH)
//  DATA_W      32  word width; multiple of 8; NB = DATA_W/8
//  READ_LAT    1   read latency in cycles from grant to rdata_valid (1 or 2)
//  ARB_MODE    RR  arb_mode_e: ARB_FIXED (lowest index wins) or ARB_RR (round-robin)
// PORTS
//  clk          in   1               clock
//  rst_n        in   1               asynchronous active-low reset
//  req          in   N_PORTS         per-channel access request
//  we           in   N_PORTS         1=write, 0=read (qualified by req)
//  addr         in   N_PORTS*AW      per-channel word address, channel p at [p*AW +: AW]
//  wdata        in   N_PORTS*DATA_W  per-channel write data
//  wstrb        in   N_PORTS*NB      per-channel byte enables
//  gnt          out  N_PORTS         one-hot (or zero) grant, combinational from req
//  rdata        out  DATA_W          shared read-data bus
//  rdata_valid  out  N_PORTS         one-hot, channel owning rdata this cycle
// BEHAVIOUR
//  Reset: rdata=0, rdata_valid=0, RR pointer=0, pipeline valids cleared. Memory array is not reset.
//  Handshake: an access fires on the posedge where req[p]&&gnt[p]. The requester holds req/we/addr/wdata/wstrb
//   stable until granted. gnt is never asserted without req. gnt=0 when req=0.
//  Arbitration:
//   ARB_FIXED: the lowest-index active req wins.
//   ARB_RR: the search starts at ptr. After a grant to p, ptr <= (p+1) mod N_PORTS; ptr holds when nothing is granted.
//   No starvation in RR: any held request is granted within N_PORTS cycles.
//  Write: mem[addr] bytes b with wstrb[b]=1 updated at the grant edge; other bytes keep their value.
//   wstrb=0 is a legal no-op that still consumes the slot and advances ptr.
//  Read:
//   READ_LAT=1: rdata and rdata_valid[p] are registered at the grant edge, so valid appears in cycle G+1.
//   READ_LAT=2: an extra register stage is added, so valid appears in cycle G+2.
//   Fully pipelined: back-to-back read grants give back-to-back valids.
//   rdata holds its last value when no valid is asserted. rdata_valid is a 1-cycle pulse.
//  Ordering: a read granted the cycle after a write to the same address returns the new data (write-first by sequencing).
//  Only one access exists per cycle, so there are no simultaneous read/write hazards.
//  Address >= MEM_DEPTH (non-power-of-2 depth): a write is dropped; a read returns 0 and still pulses valid.
//  Reset mid-operation: in-flight read valids are discarded; no valid pulse appears after rst_n deasserts.
//  Assertions:
//   $onehot0(gnt) and $onehot0(rdata_valid).
//   gnt[p] implies req[p].
//   With READ_LAT=1, rdata_valid[p] implies a read grant to p one cycle earlier.
// STRUCTURE
//  Package mem_ctrl_pkg:
//   typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e.
//   Function strb_merge(old, new, strb) for the byte-masked write.
//  Sub-module rr_arbiter #(N, MODE): inputs req and ptr-update enable; outputs one-hot gnt and the
//   granted index. It owns the ptr register. The top level holds the array, read pipe and port mux.
// TESTING
//  1. Single read: write ch0 addr 5 = 0xDEADBEEF with wstrb=0xF, then read ch2 addr 5.
//     -> rdata=0xDEADBEEF, rdata_valid=4'b0100 one cycle after grant (READ_LAT=1).
//  2. Byte strobe: mem[3]=0x11223344, then write 0xAABBCCDD with wstrb=4'b0101.
//     -> a read of addr 3 returns 0x11BB33DD.
//  3. RR fairness: all 4 channels hold read req for 8 cycles, ARB_RR, ptr=0.
//     -> grants ch0,1,2,3,0,1,2,3; each rdata_valid pulse is 1 cycle later with matching data.
//  4. Fixed priority: ch1 and ch3 request every cycle, ARB_FIXED.
//     -> ch1 is granted every cycle; ch3 is never granted until ch1 drops req.
//  5. READ_LAT=2 pipelining: 3 back-to-back reads from ch0 at addrs 0,1,2.
//     -> valids in cycles G+2..G+4 with the correct data in order.
//  6. Reset mid-flight: assert rst_n low in the cycle after a read grant.
//     -> no rdata_valid pulse appears; rdata=0 and ptr=0 after release.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the multi-port memory arbiter/controller.
package mem_ctrl_pkg;

    // Arbitration policy: lowest index wins, or rotating priority.
    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Byte-lane merge for a masked write: take the new byte where the strobe is set.
    function automatic logic [7:0] strb_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       strb);
        return strb ? new_b : old_b;
    endfunction

endpackage

// File: rtl/mem_arb_ctrl_if.sv
// Requester-side bus of the memory arbiter: all channels packed side by side.
//
// Handshake: an access transfers on the rising clock edge where req[p] and gnt[p]
// are both high. The requester keeps req/we/addr/wdata/wstrb for channel p stable
// until it sees gnt[p]; gnt is combinational from req and never high without req.
// Read data comes back later on the shared rdata bus, tagged by a one-cycle
// rdata_valid[p] pulse; there is no back-pressure on the return path.
interface mem_arb_ctrl_if #(
    parameter int N_PORTS = 4,
    parameter int AW      = 5,
    parameter int DATA_W  = 32
);
    localparam int NB = DATA_W / 8;

    logic [N_PORTS-1:0]        req;
    logic [N_PORTS-1:0]        we;
    logic [N_PORTS*AW-1:0]     addr;
    logic [N_PORTS*DATA_W-1:0] wdata;
    logic [N_PORTS*NB-1:0]     wstrb;
    logic [N_PORTS-1:0]        gnt;
    logic [DATA_W-1:0]         rdata;
    logic [N_PORTS-1:0]        rdata_valid;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  gnt, rdata, rdata_valid
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output gnt, rdata, rdata_valid
    );

endinterface

// File: rtl/rr_arbiter.sv
// N-way arbiter: fixed lowest-index priority or round-robin starting at ptr.
// The rotating pointer lives here; it moves past the winner on each accepted grant.
module rr_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int        N    = 4,
    parameter arb_mode_e MODE = ARB_RR,
    localparam int       IW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic          upd_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic [IW-1:0] ptr_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] start;
    logic          found;
    int            cand;

    // Pick the first requester at or after the search start, wrapping around.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        start = (MODE == ARB_RR) ? ptr_q : '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(start) + k;
            if (cand >= N) cand = cand - N;
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = IW'(cand);
            end
        end
    end

    // Pointer moves to the slot after the winner; holds on idle cycles.
    always_comb begin
        ptr_d = ptr_q;
        if (upd_i && found) begin
            ptr_d = (int'(idx_o) == N - 1) ? '0 : idx_o + IW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/mem_arb_ctrl.sv
// Multi-requester front end for a single-port word memory: one access per cycle,
// byte-strobed writes, pipelined reads tagged per channel.
module mem_arb_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int        N_PORTS   = 4,
    parameter int        MEM_DEPTH = 32,
    parameter int        DATA_W    = 32,
    parameter int        READ_LAT  = 1,
    parameter arb_mode_e ARB_MODE  = ARB_RR,
    localparam int       AW        = $clog2(MEM_DEPTH),
    localparam int       NB        = DATA_W / 8,
    localparam int       IW        = $clog2(N_PORTS)
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arb_ctrl_if.slave bus,
    output logic [IW-1:0] dbg_ptr_o
);

    logic [N_PORTS-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic               fire;

    logic               sel_we;
    logic [AW-1:0]      sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [NB-1:0]      sel_wstrb;
    logic               in_range;
    logic [DATA_W-1:0]  cur_word;
    logic [DATA_W-1:0]  wr_word;
    logic               rd_fire;

    logic [DATA_W-1:0]  mem_q [MEM_DEPTH];

    logic [N_PORTS-1:0] v1_q, v1_d;
    logic [DATA_W-1:0]  d1_q, d1_d;

    rr_arbiter #(.N(N_PORTS), .MODE(ARB_MODE)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (bus.req),
        .upd_i (fire),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .ptr_o (dbg_ptr_o)
    );

    assign bus.gnt = gnt;
    assign fire    = |gnt;

    // Route the winning channel's command; out-of-range addresses read as zero.
    always_comb begin
        sel_we    = bus.we[gnt_idx];
        sel_addr  = bus.addr[gnt_idx*AW +: AW];
        sel_wdata = bus.wdata[gnt_idx*DATA_W +: DATA_W];
        sel_wstrb = bus.wstrb[gnt_idx*NB +: NB];
        in_range  = int'(sel_addr) < MEM_DEPTH;
        cur_word  = in_range ? mem_q[sel_addr] : '0;
        rd_fire   = fire && !sel_we;
        wr_word   = cur_word;
        for (int b = 0; b < NB; b++) begin
            wr_word[b*8 +: 8] = strb_merge(cur_word[b*8 +: 8], sel_wdata[b*8 +: 8], sel_wstrb[b]);
        end
    end

    // Memory array: byte-masked write at the grant edge; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (fire && sel_we && in_range) mem_q[sel_addr] <= wr_word;
    end

    // First read stage next-state: capture the word and the owner on a read grant.
    always_comb begin
        v1_d = rd_fire ? gnt : '0;
        d1_d = rd_fire ? cur_word : d1_q;
    end

    // First read stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= '0;
            d1_q <= '0;
        end else begin
            v1_q <= v1_d;
            d1_q <= d1_d;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [N_PORTS-1:0] v2_q;
            logic [DATA_W-1:0]  d2_q;

            // Second read stage: delay valid and data one more cycle, hold data when idle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v2_q <= '0;
                    d2_q <= '0;
                end else begin
                    v2_q <= v1_q;
                    if (|v1_q) d2_q <= d1_q;
                end
            end

            assign bus.rdata       = d2_q;
            assign bus.rdata_valid = v2_q;
        end else begin : g_lat1
            assign bus.rdata       = d1_q;
            assign bus.rdata_valid = v1_q;
        end
    endgenerate

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.rdata_valid));
    a_gnt_has_req: assert property (@(posedge clk) disable iff (!rst_n) (gnt & ~bus.req) == '0);

    generate
        if (READ_LAT == 1) begin : g_lat1_chk
            a_valid_src: assert property (@(posedge clk) disable iff (!rst_n)
                (|bus.rdata_valid) |-> (bus.rdata_valid == $past(gnt & ~bus.we)));
        end
    endgenerate

endmodule
